// File: rtl/sha256_digest_serializer_if.sv
// rtl/sha256_digest_serializer_if.sv - byte stream handshake bundle for the digest serializer
interface sha256_digest_serializer_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;

    modport master (
        output byte_out,
        output byte_valid,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        input  byte_last,
        output byte_ready
    );
endinterface

// File: rtl/sha256_digest_serializer.sv
// rtl/sha256_digest_serializer.sv - captures a 256-bit digest on done rise and streams it MSB first
module sha256_digest_serializer #(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [255:0]                    hash_in,
    input  logic                            hash_done,
    sha256_digest_serializer_if.master      stream,
    output logic                            busy,
    output logic                            overrun
);
    localparam logic [6:0] LAST_CNT = HEX_MODE ? 7'd63 : 7'd31;

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state, state_next;
    logic         done_q;
    logic [255:0] shreg, shreg_next;
    logic [6:0]   cnt, cnt_next;
    logic         overrun_next;
    logic         rise, fire, at_last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign rise    = hash_done & ~done_q;
    assign fire    = (state == SEND) & stream.byte_ready;
    assign at_last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            shreg   <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            done_q  <= hash_done;
            shreg   <= shreg_next;
            cnt     <= cnt_next;
            overrun <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        cnt_next     = cnt;
        overrun_next = overrun;
        case (state)
            IDLE: begin
                if (rise) begin
                    shreg_next = hash_in;
                    cnt_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    cnt_next = cnt + 7'd1;
                    // Hex mode spends two characters on each byte before shifting it out.
                    if (!HEX_MODE || cnt[0])
                        shreg_next = {shreg[247:0], 8'h00};
                    if (at_last) begin
                        if (rise) begin
                            shreg_next = hash_in;
                            cnt_next   = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                if (rise && !(fire && at_last))
                    overrun_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stream.byte_out   = 8'h00;
        stream.byte_valid = 1'b0;
        stream.byte_last  = 1'b0;
        busy              = 1'b0;
        if (state == SEND) begin
            stream.byte_valid = 1'b1;
            stream.byte_last  = at_last;
            busy              = 1'b1;
            if (!HEX_MODE)
                stream.byte_out = shreg[255:248];
            else if (!cnt[0])
                stream.byte_out = hex_char(shreg[255:252]);
            else
                stream.byte_out = hex_char(shreg[251:248]);
        end
    end
endmodule
